// File: rtl/slow_clk_pkg.sv
// Shared types, default constants and helpers for the slow clock monitor.
package slow_clk_pkg;

    // Default configuration of the monitor.
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_LOCK_EDGES  = 4;
    localparam int DEF_TOL         = 1;

    // Width used for measurement differences. It covers one extra bit
    // over the counter so that cnt+1 never wraps, for CNT_W up to 32.
    localparam int DIFF_W = 33;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_e;

    // Unsigned magnitude of the difference between two measurements.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/slow_clk_monitor_sync_edge_det.sv
// Synchronizer for an asynchronous slow signal plus registered edge pulses.
// SYNC_STAGES must be at least 2.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   edge_q;
    logic                   sync_s;
    logic                   rise_d;
    logic                   fall_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Edge detect between the synchronized level and the previous sample.
    always_comb begin
        rise_d = sync_s & ~prev_q;
        fall_d = ~sync_s & prev_q;
    end

    // Synchronizer chain, previous-sample flop and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_s;
            rise_q <= rise_d;
            fall_q <= fall_d;
            edge_q <= rise_d | fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign edge_o = edge_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow clock monitor: edge enables, half-period measurement and lock/loss
// tracking of a slow square wave seen from the fast clk domain.
//
// state  | meaning
// IDLE   | after reset, waiting for the first edge (counter runs from reset)
// ACQ    | measuring; counting consecutive matching half-periods
// LOCKED | LOCK_EDGES matching measurements seen; tracking within TOL
// LOST   | no edge for TIMEOUT cycles; next edge restarts acquisition
module slow_clk_monitor
    import slow_clk_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int LOCK_EDGES  = DEF_LOCK_EDGES,
    parameter int TOL         = DEF_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_in_i,
    output logic             rise_pulse_o,
    output logic             fall_pulse_o,
    output logic             edge_pulse_o,
    output logic [CNT_W-1:0] half_period_o,
    output logic             locked_o,
    output logic             lost_o
);

    localparam int MW = $clog2(LOCK_EDGES + 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] half_period_q;
    logic [CNT_W-1:0] half_period_d;
    logic [CNT_W:0]   prev_meas_q;
    logic [CNT_W:0]   prev_meas_d;
    logic [MW-1:0]    match_cnt_q;
    logic [MW-1:0]    match_cnt_d;
    logic             have_ref_q;
    logic             have_ref_d;

    logic             edge_s;
    logic [CNT_W:0]   meas;
    logic [CNT_W-1:0] meas_sat;
    logic [MW-1:0]    match_inc;
    logic             meas_match;
    logic             timeout_hit;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (slow_in_i),
        .rise_o (rise_pulse_o),
        .fall_o (fall_pulse_o),
        .edge_o (edge_s)
    );

    assign edge_pulse_o = edge_s;

    // Measurement and compare against the previous accepted measurement.
    // A saturated counter yields 2^CNT_W, which is clamped for half_period.
    always_comb begin
        meas        = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        meas_sat    = meas[CNT_W] ? '1 : meas[CNT_W-1:0];
        match_inc   = match_cnt_q + MW'(1);
        meas_match  = abs_diff(DIFF_W'(meas), DIFF_W'(prev_meas_q)) <= DIFF_W'(TOL);
        timeout_hit = !edge_s && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Edge-to-edge cycle counter, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_s) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state and datapath update; an edge always beats the timeout.
    always_comb begin
        state_d       = state_q;
        have_ref_d    = have_ref_q;
        match_cnt_d   = match_cnt_q;
        prev_meas_d   = prev_meas_q;
        half_period_d = half_period_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    state_d    = ST_ACQ;
                    have_ref_d = 1'b0;
                end
            end
            ST_ACQ: begin
                if (edge_s) begin
                    prev_meas_d   = meas;
                    half_period_d = meas_sat;
                    if (!have_ref_q) begin
                        have_ref_d  = 1'b1;
                        match_cnt_d = '0;
                    end else if (meas_match) begin
                        match_cnt_d = match_inc;
                        if (match_inc == MW'(LOCK_EDGES)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (edge_s) begin
                    prev_meas_d   = meas;
                    half_period_d = meas_sat;
                    if (!meas_match) begin
                        state_d     = ST_ACQ;
                        have_ref_d  = 1'b1;
                        match_cnt_d = '0;
                    end
                end
            end
            ST_LOST: begin
                if (edge_s) begin
                    state_d    = ST_ACQ;
                    have_ref_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout_hit && (state_q != ST_LOST)) begin
            state_d     = ST_LOST;
            match_cnt_d = '0;
            have_ref_d  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter and measurement registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            half_period_q <= '0;
            prev_meas_q   <= '0;
            match_cnt_q   <= '0;
            have_ref_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            half_period_q <= half_period_d;
            prev_meas_q   <= prev_meas_d;
            match_cnt_q   <= match_cnt_d;
            have_ref_q    <= have_ref_d;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        locked_o = (state_q == ST_LOCKED);
        lost_o   = (state_q == ST_LOST);
    end

    assign half_period_o = half_period_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor with default parameters.
module tb_slow_clk_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        slow_in;
    logic        rise_pulse;
    logic        fall_pulse;
    logic        edge_pulse;
    logic [15:0] half_period;
    logic        locked;
    logic        lost;

    logic        lvl;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          gap;
        logic [15:0] half;
        logic        lck;
    } vec_t;

    vec_t vec [16];

    slow_clk_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .slow_in_i     (slow_in),
        .rise_pulse_o  (rise_pulse),
        .fall_pulse_o  (fall_pulse),
        .edge_pulse_o  (edge_pulse),
        .half_period_o (half_period),
        .locked_o      (locked),
        .lost_o        (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"},   {31'd0, rise_pulse}, 32'd0);
        chk({tag, "_fall"},   {31'd0, fall_pulse}, 32'd0);
        chk({tag, "_edge"},   {31'd0, edge_pulse}, 32'd0);
        chk({tag, "_half"},   {16'd0, half_period}, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
        chk({tag, "_lost"},   {31'd0, lost}, 32'd0);
    endtask

    // Called just after a negedge. Optionally toggles slow_in, then spends
    // gap cycles: pulse expected 3 cycles later, status one cycle after that.
    task automatic edge_step(input int gap, input bit toggle, input logic [15:0] eh,
                             input logic el, input logic elost, input string tag);
        if (toggle) begin
            lvl     = ~lvl;
            slow_in = lvl;
        end
        for (int i = 1; i <= gap; i++) begin
            @(negedge clk);
            if (i == 3) begin
                chk({tag, "_rise"}, {31'd0, rise_pulse}, {31'd0, lvl});
                chk({tag, "_fall"}, {31'd0, fall_pulse}, {31'd0, !lvl});
                chk({tag, "_edge"}, {31'd0, edge_pulse}, 32'd1);
            end else begin
                chk($sformatf("%s_noedge%0d", tag, i), {31'd0, edge_pulse}, 32'd0);
            end
            if (i == 4) begin
                chk({tag, "_half"},   {16'd0, half_period}, {16'd0, eh});
                chk({tag, "_locked"}, {31'd0, locked}, {31'd0, el});
                chk({tag, "_lost"},   {31'd0, lost}, {31'd0, elost});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Edge k: toggle, expected status after edge k, gap to edge k+1.
        vec[0]  = '{9,  16'd0,  1'b0};
        vec[1]  = '{9,  16'd9,  1'b0};
        vec[2]  = '{9,  16'd9,  1'b0};
        vec[3]  = '{9,  16'd9,  1'b0};
        vec[4]  = '{9,  16'd9,  1'b0};
        vec[5]  = '{9,  16'd9,  1'b1};
        vec[6]  = '{10, 16'd9,  1'b1};
        vec[7]  = '{9,  16'd10, 1'b1};
        vec[8]  = '{8,  16'd9,  1'b1};
        vec[9]  = '{9,  16'd8,  1'b1};
        vec[10] = '{14, 16'd9,  1'b1};
        vec[11] = '{9,  16'd14, 1'b0};
        vec[12] = '{9,  16'd9,  1'b0};
        vec[13] = '{9,  16'd9,  1'b0};
        vec[14] = '{9,  16'd9,  1'b0};
        vec[15] = '{9,  16'd9,  1'b0};

        rst     = 1'b1;
        slow_in = 1'b0;
        lvl     = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Acquisition, lock, jitter tolerance, one bad interval and relock.
        for (int k = 0; k < 16; k++) begin
            edge_step(vec[k].gap, 1'b1, vec[k].half, vec[k].lck, 1'b0, $sformatf("s1_e%0d", k + 1));
        end

        // Edge 17 relocks, then the wave stops until timeout.
        lvl     = ~lvl;
        slow_in = lvl;
        for (int i = 1; i <= 1040; i++) begin
            @(negedge clk);
            if (i == 3) chk("s4_e17_edge", {31'd0, edge_pulse}, 32'd1);
            if (i == 4) begin
                chk("s4_e17_locked", {31'd0, locked}, 32'd1);
                chk("s4_e17_half", {16'd0, half_period}, 32'd9);
            end
            if (i == 1027) begin
                chk("s4_prelost_lost", {31'd0, lost}, 32'd0);
                chk("s4_prelost_locked", {31'd0, locked}, 32'd1);
            end
            if (i == 1028) begin
                chk("s4_lost", {31'd0, lost}, 32'd1);
                chk("s4_lost_locked", {31'd0, locked}, 32'd0);
                chk("s4_lost_half", {16'd0, half_period}, 32'd9);
            end
        end
        edge_step(20, 1'b1, 16'd9,  1'b0, 1'b0, "s4_e18");
        edge_step(6,  1'b1, 16'd20, 1'b0, 1'b0, "s4_e19");

        // Reset with slow_in high: a single rise after release.
        rst     = 1'b1;
        lvl     = 1'b1;
        slow_in = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("s5_reset");
        rst = 1'b0;
        edge_step(12, 1'b0, 16'd0,  1'b0, 1'b0, "s5_e1");
        edge_step(9,  1'b1, 16'd12, 1'b0, 1'b0, "s5_e2");
        for (int k = 3; k <= 6; k++) begin
            edge_step(9, 1'b1, 16'd9, 1'b0, 1'b0, $sformatf("s5_e%0d", k));
        end
        edge_step(5, 1'b1, 16'd9, 1'b1, 1'b0, "s5_e7");

        // One-cycle reset while locked, with a falling edge in flight.
        lvl     = 1'b0;
        slow_in = 1'b0;
        @(negedge clk);
        chk("s6_pre_locked", {31'd0, locked}, 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("s6_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("s6_dropped%0d", i), {31'd0, edge_pulse}, 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            edge_step(vec[k].gap, 1'b1, vec[k].half, vec[k].lck, 1'b0, $sformatf("s6_e%0d", k + 1));
        end
        // Interval of exactly TIMEOUT: the edge lands on cnt == TIMEOUT-1.
        edge_step(1024, 1'b1, 16'd9,    1'b1, 1'b0, "s6_e6");
        edge_step(6,    1'b1, 16'd1024, 1'b0, 1'b0, "s6_e7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
